pulse_scan_scheduler: RTL and testbench

PULSE_SCAN_SCHEDULER -- requirements
Module: pulse_scan_scheduler

---
 rtl/pulse_scan_scheduler.sv | 155 +++++++++++++++
 tb/tb_pulse_scan_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_scan_scheduler.sv
// Pulse scan scheduler: runs a configurable number of pulser scans, stepping the
// transmit phase through a cyclic table with idle time between scans.
module pulse_scan_scheduler #(
    parameter int          PHASE_W  = 5,
    parameter int          N_PHASES = 4,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] WDOG     = 32'd1000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [CNT_W-1:0]            num_scans,
    input  logic [31:0]                 rep_delay,
    input  logic [N_PHASES*PHASE_W-1:0] phase_table,
    input  logic [2:0]                  cycle_len,
    input  logic                        pulser_done,
    output logic                        pulser_enable,
    output logic [PHASE_W-1:0]          tx_phase,
    output logic [CNT_W-1:0]            scan_count,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);
    localparam int IDX_W = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;
    localparam int LEN_W = $clog2(N_PHASES + 1);
    localparam int TBL_W = N_PHASES * PHASE_W;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DELAY, FINISH} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   num_scans_q, num_scans_nx;
    logic [31:0]        rep_delay_q, rep_delay_nx;
    logic [TBL_W-1:0]   table_q, table_nx;
    logic [LEN_W-1:0]   eff_len, eff_len_nx;
    logic [IDX_W-1:0]   phase_idx, phase_idx_nx;
    logic [31:0]        wdog_cnt, wdog_cnt_nx;
    logic [31:0]        delay_cnt, delay_cnt_nx;
    logic               pulser_enable_nx;
    logic [PHASE_W-1:0] tx_phase_nx;
    logic [CNT_W-1:0]   scan_count_nx;
    logic               busy_nx, done_nx, error_nx;
    logic               wdog_expired;

    // The watchdog fires on the WDOG-th RUN cycle; widened so WDOG=0 cannot wrap.
    assign wdog_expired = ({1'b0, wdog_cnt} + 33'd1) >= {1'b0, WDOG};

    always_comb begin
        state_nx         = state;
        num_scans_nx     = num_scans_q;
        rep_delay_nx     = rep_delay_q;
        table_nx         = table_q;
        eff_len_nx       = eff_len;
        phase_idx_nx     = phase_idx;
        wdog_cnt_nx      = wdog_cnt;
        delay_cnt_nx     = delay_cnt;
        pulser_enable_nx = 1'b0;
        tx_phase_nx      = tx_phase;
        scan_count_nx    = scan_count;
        error_nx         = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    num_scans_nx  = num_scans;
                    rep_delay_nx  = rep_delay;
                    table_nx      = phase_table;
                    eff_len_nx    = (cycle_len == 3'd0 || 32'(cycle_len) > 32'(N_PHASES))
                                    ? LEN_W'(N_PHASES) : LEN_W'(cycle_len);
                    scan_count_nx = '0;
                    phase_idx_nx  = '0;
                    state_nx      = (num_scans != '0) ? LOAD : FINISH;
                end
            end
            LOAD: begin
                tx_phase_nx = table_q[int'(phase_idx) * PHASE_W +: PHASE_W];
                wdog_cnt_nx = '0;
                state_nx    = RUN;
            end
            RUN: begin
                if (pulser_done) begin
                    scan_count_nx = scan_count + CNT_W'(1);
                    delay_cnt_nx  = (rep_delay_q == 32'd0) ? 32'd0 : rep_delay_q - 32'd1;
                    state_nx      = (scan_count_nx == num_scans_q) ? FINISH : DELAY;
                end else if (wdog_expired) begin
                    error_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wdog_cnt_nx      = wdog_cnt + 32'd1;
                    pulser_enable_nx = 1'b1;
                end
            end
            DELAY: begin
                if (delay_cnt == 32'd0) begin
                    phase_idx_nx = ((LEN_W'(phase_idx) + LEN_W'(1)) >= eff_len)
                                   ? '0 : phase_idx + IDX_W'(1);
                    state_nx     = LOAD;
                end else begin
                    delay_cnt_nx = delay_cnt - 32'd1;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Abort overrides everything a busy state decided, including a coincident pulser_done.
        if (state != IDLE && abort) begin
            state_nx         = IDLE;
            scan_count_nx    = scan_count;
            pulser_enable_nx = 1'b0;
            error_nx         = 1'b1;
        end

        done_nx = (state_nx == FINISH);
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            num_scans_q   <= '0;
            rep_delay_q   <= '0;
            table_q       <= '0;
            eff_len       <= '0;
            phase_idx     <= '0;
            wdog_cnt      <= '0;
            delay_cnt     <= '0;
            pulser_enable <= 1'b0;
            tx_phase      <= '0;
            scan_count    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_nx;
            num_scans_q   <= num_scans_nx;
            rep_delay_q   <= rep_delay_nx;
            table_q       <= table_nx;
            eff_len       <= eff_len_nx;
            phase_idx     <= phase_idx_nx;
            wdog_cnt      <= wdog_cnt_nx;
            delay_cnt     <= delay_cnt_nx;
            pulser_enable <= pulser_enable_nx;
            tx_phase      <= tx_phase_nx;
            scan_count    <= scan_count_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            error         <= error_nx;
        end
    end
endmodule

// File: tb/tb_pulse_scan_scheduler.sv
// Bench for pulse_scan_scheduler: directed vector table, corner-case sequences and
// randomized experiments checked against a scan-level reference model.
module tb_pulse_scan_scheduler;
    localparam int PHASE_W  = 5;
    localparam int N_PHASES = 4;
    localparam int CNT_W    = 16;
    localparam int WDOG     = 50;
    localparam int TBL_W    = N_PHASES * PHASE_W;

    logic               clk = 1'b0;
    logic               rst_n, start, abort_manual;
    logic               abort_auto = 1'b0;
    logic               abort;
    logic [CNT_W-1:0]   num_scans;
    logic [31:0]        rep_delay;
    logic [TBL_W-1:0]   phase_table;
    logic [2:0]         cycle_len;
    logic               pulser_done = 1'b0;
    logic               pulser_enable;
    logic [PHASE_W-1:0] tx_phase;
    logic [CNT_W-1:0]   scan_count;
    logic               busy, done, error;

    assign abort = abort_manual | abort_auto;
    always #5 clk = ~clk;

    pulse_scan_scheduler #(
        .PHASE_W(PHASE_W), .N_PHASES(N_PHASES), .CNT_W(CNT_W), .WDOG(32'(WDOG))
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_scans(num_scans), .rep_delay(rep_delay), .phase_table(phase_table),
        .cycle_len(cycle_len), .pulser_done(pulser_done),
        .pulser_enable(pulser_enable), .tx_phase(tx_phase), .scan_count(scan_count),
        .busy(busy), .done(done), .error(error)
    );

    typedef struct {
        logic [CNT_W-1:0] n;
        logic [31:0]      rep;
        logic [2:0]       cl;
        logic [TBL_W-1:0] tbl;
        int               resp;
        int               exp_scans;
        int               exp_dones;
        int               exp_errs;
        int               exp_busy;
        int               exp_gap;
        int               exp_len;
        logic [44:0]      exp_seq;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int resp_delay;
    int abort_on_scan;
    int start_cyc;

    logic               prev_en = 1'b0;
    logic               fall_valid = 1'b0;
    logic [PHASE_W-1:0] cur_phase = '0;
    int resp_cnt = 0, done_num = 0;
    int done_total = 0, err_total = 0, busy_total = 0, unstable = 0;
    int last_fall = 0, last_err = 0;
    logic [PHASE_W-1:0] phase_q[$];
    int rise_q[$];
    int gap_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulser stand-in and observer: answers each enable after resp_delay cycles
    // (0 = never) and logs phases, gaps, pulses and busy time.
    always @(negedge clk) begin
        if (pulser_done) pulser_done = 1'b0;
        if (abort_auto) abort_auto = 1'b0;
        if (done) done_total++;
        if (error) begin
            err_total++;
            last_err = cyc;
        end
        if (busy) busy_total++;
        else fall_valid = 1'b0;
        if (pulser_enable && prev_en && tx_phase != cur_phase) unstable++;
        if (pulser_enable && !prev_en) begin
            phase_q.push_back(tx_phase);
            rise_q.push_back(cyc);
            cur_phase = tx_phase;
            if (fall_valid) gap_q.push_back(cyc - last_fall);
            resp_cnt = resp_delay;
        end else if (pulser_enable && resp_cnt != 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                pulser_done = 1'b1;
                done_num++;
                if (done_num == abort_on_scan) abort_auto = 1'b1;
            end
        end
        if (!pulser_enable && prev_en) begin
            last_fall  = cyc;
            fall_valid = 1'b1;
        end
        prev_en = pulser_enable;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " pulser_enable"}, 32'(pulser_enable), 0);
        check_output({tag, " tx_phase"}, 32'(tx_phase), 0);
        check_output({tag, " scan_count"}, 32'(scan_count), 0);
        check_output({tag, " busy"}, 32'(busy), 0);
        check_output({tag, " done"}, 32'(done), 0);
        check_output({tag, " error"}, 32'(error), 0);
    endtask

    // Scan-level reference: phase k is table entry (k mod effective length); each scan
    // costs LOAD + (resp+2) RUN cycles, scans are separated by max(rep,1) DELAY cycles.
    function automatic vec_t model(input logic [CNT_W-1:0] n, input logic [31:0] rep,
                                   input logic [2:0] cl, input logic [TBL_W-1:0] tbl, input int resp);
        vec_t v;
        int   eff;
        int   r;
        v.n = n; v.rep = rep; v.cl = cl; v.tbl = tbl; v.resp = resp;
        eff = (cl == 3'd0 || int'(cl) > N_PHASES) ? N_PHASES : int'(cl);
        r = (rep == 32'd0) ? 1 : int'(rep);
        v.exp_gap = r + 2;
        v.exp_seq = '0;
        if (n == '0) begin
            v.exp_scans = 0; v.exp_dones = 1; v.exp_errs = 0; v.exp_busy = 1; v.exp_len = 0;
        end else if (resp == 0) begin
            v.exp_scans = 0; v.exp_dones = 0; v.exp_errs = 1; v.exp_busy = 1 + WDOG; v.exp_len = 1;
            v.exp_seq[PHASE_W-1:0] = tbl[PHASE_W-1:0];
        end else begin
            v.exp_scans = int'(n); v.exp_dones = 1; v.exp_errs = 0; v.exp_len = int'(n);
            v.exp_busy = int'(n) * (resp + 3) + (int'(n) - 1) * r + 1;
            for (int k = 0; k < int'(n); k++)
                v.exp_seq[k*PHASE_W +: PHASE_W] = tbl[(k % eff)*PHASE_W +: PHASE_W];
        end
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v, input int id);
        int    snap_ph, snap_gap, snap_done, snap_err, snap_busy, snap_unst, waited, got_len, exp_gaps;
        string tag;
        tag = $sformatf("case%0d", id);
        @(negedge clk);
        num_scans = v.n; rep_delay = v.rep; cycle_len = v.cl; phase_table = v.tbl; resp_delay = v.resp;
        snap_ph = phase_q.size(); snap_gap = gap_q.size(); snap_done = done_total;
        snap_err = err_total; snap_busy = busy_total; snap_unst = unstable;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        waited = 0;
        while (busy && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        check_output({tag, " finished in time"}, 32'(waited < 5000), 1);
        check_output({tag, " scan_count"}, 32'(scan_count), v.exp_scans);
        check_output({tag, " done pulses"}, done_total - snap_done, v.exp_dones);
        check_output({tag, " error pulses"}, err_total - snap_err, v.exp_errs);
        check_output({tag, " busy cycles"}, busy_total - snap_busy, v.exp_busy);
        check_output({tag, " tx_phase stable in RUN"}, unstable - snap_unst, 0);
        got_len = phase_q.size() - snap_ph;
        check_output({tag, " enable count"}, got_len, v.exp_len);
        for (int k = 0; k < got_len && k < v.exp_len; k++)
            check_output($sformatf("%s phase[%0d]", tag, k), 32'(phase_q[snap_ph + k]),
                         32'(v.exp_seq[k*PHASE_W +: PHASE_W]));
        if (got_len > 0)
            check_output({tag, " start-to-enable latency"}, rise_q[snap_ph] - start_cyc, 2);
        exp_gaps = (v.exp_len > 0 && v.exp_errs == 0) ? v.exp_len - 1 : 0;
        check_output({tag, " gap count"}, gap_q.size() - snap_gap, exp_gaps);
        for (int k = snap_gap; k < gap_q.size(); k++)
            check_output($sformatf("%s gap[%0d]", tag, k - snap_gap), gap_q[k], v.exp_gap);
        if (waited >= 5000) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    vec_t vecs[7];

    initial begin
        int snap_err, snap_done, waited, snap_ph;
        rst_n = 1'b0; start = 1'b0; abort_manual = 1'b0;
        num_scans = '0; rep_delay = '0; phase_table = '0; cycle_len = '0;
        resp_delay = 0; abort_on_scan = 0; start_cyc = 0;

        vecs[0] = '{16'd3, 32'd10, 3'd2, {5'd0, 5'd0, 5'd18, 5'd9}, 20, 3, 1, 0, 90, 12, 3,
                    45'({5'd9, 5'd18, 5'd9})};
        vecs[1] = '{16'd0, 32'd4, 3'd2, {5'd1, 5'd2, 5'd3, 5'd4}, 5, 0, 1, 0, 1, 6, 0, 45'd0};
        vecs[2] = '{16'd9, 32'd2, 3'd4, {5'd3, 5'd2, 5'd1, 5'd0}, 3, 9, 1, 0, 71, 4, 9,
                    45'({5'd0, 5'd3, 5'd2, 5'd1, 5'd0, 5'd3, 5'd2, 5'd1, 5'd0})};
        vecs[3] = '{16'd5, 32'd0, 3'd6, {5'd4, 5'd3, 5'd2, 5'd1}, 5, 5, 1, 0, 45, 3, 5,
                    45'({5'd1, 5'd4, 5'd3, 5'd2, 5'd1})};
        vecs[4] = '{16'd3, 32'd3, 3'd1, {5'd7, 5'd6, 5'd5, 5'd31}, 2, 3, 1, 0, 22, 5, 3,
                    45'({5'd31, 5'd31, 5'd31})};
        vecs[5] = '{16'd4, 32'd1, 3'd3, {5'd20, 5'd12, 5'd11, 5'd10}, 7, 4, 1, 0, 44, 3, 4,
                    45'({5'd10, 5'd12, 5'd11, 5'd10})};
        vecs[6] = '{16'd2, 32'd5, 3'd0, {5'd8, 5'd7, 5'd6, 5'd25}, 0, 0, 0, 1, 51, 7, 1,
                    45'(5'd25)};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], i);
        // Row 6 never answers the pulser: error is due WDOG cycles after RUN entry.
        check_output("watchdog error timing", last_err - start_cyc, WDOG + 1);

        // A finished run leaves scan_count at 3; abort alone or with start in IDLE changes nothing.
        apply_stimulus(model(16'd3, 32'd1, 3'd2, {5'd1, 5'd2, 5'd3, 5'd4}, 4), 10);
        snap_err = err_total;
        abort_manual = 1'b1;
        @(negedge clk);
        abort_manual = 1'b0;
        num_scans = 16'd2;
        start = 1'b1;
        abort_manual = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort_manual = 1'b0;
        check_output("start+abort busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        check_output("idle abort error pulses", err_total - snap_err, 0);
        check_output("idle scan_count held", 32'(scan_count), 3);

        // Abort coincident with the 2nd pulser_done.
        @(negedge clk);
        num_scans = 16'd4; rep_delay = 32'd3; cycle_len = 3'd2; resp_delay = 6;
        abort_on_scan = done_num + 2;
        snap_err = err_total; snap_done = done_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (busy && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        abort_on_scan = 0;
        repeat (2) @(negedge clk);
        check_output("abort finished in time", 32'(waited < 2000), 1);
        check_output("abort scan_count", 32'(scan_count), 1);
        check_output("abort error pulses", err_total - snap_err, 1);
        check_output("abort done pulses", done_total - snap_done, 0);
        check_output("abort enable low next cycle", last_fall - last_err, 0);

        // Reset during DELAY after the 2nd scan, then a new run must start at phase index 0.
        @(negedge clk);
        num_scans = 16'd4; rep_delay = 32'd8; cycle_len = 3'd2; resp_delay = 3;
        phase_table = {5'd0, 5'd0, 5'd22, 5'd11};
        snap_ph = phase_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!(phase_q.size() >= snap_ph + 2 && !pulser_enable) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check_output("reached 2nd delay", 32'(waited < 2000), 1);
        repeat (3) @(negedge clk);
        snap_err = err_total; snap_done = done_total;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid-run reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_output("reset error pulses", err_total - snap_err, 0);
        check_output("reset done pulses", done_total - snap_done, 0);
        apply_stimulus(model(16'd2, 32'd2, 3'd2, {5'd0, 5'd0, 5'd14, 5'd13}, 2), 20);

        for (int i = 0; i < 10; i++) begin
            int r_resp;
            r_resp = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
            apply_stimulus(model(CNT_W'($urandom_range(0, 9)), 32'($urandom_range(0, 6)),
                                 3'($urandom_range(0, 7)), TBL_W'($urandom), r_resp), 100 + i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
